// File: rtl/operand_queue.sv
// Operand buffer between one VRF accesser output and its consuming VFU.
// Binds streamed operand words to per-instruction commands and tags them with ID and last flag.
module operand_queue #(
  parameter int Depth     = 4,
  parameter int CmdDepth  = 2,
  parameter int DataWidth = 32,
  parameter int IdWidth   = 4,
  parameter int CntWidth  = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [CntWidth-1:0]          cmd_cnt_i,
  input  logic [IdWidth-1:0]           cmd_id_i,
  input  logic                         opnd_valid_i,
  output logic                         opnd_ready_o,
  input  logic [DataWidth-1:0]         opnd_i,
  output logic                         vfu_valid_o,
  input  logic                         vfu_ready_i,
  output logic [DataWidth-1:0]         vfu_operand_o,
  output logic [IdWidth-1:0]           vfu_id_o,
  output logic                         vfu_last_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int PtrW  = $clog2(Depth);
  localparam int CntW  = $clog2(Depth + 1);
  localparam int CPtrW = $clog2(CmdDepth);
  localparam int CCntW = $clog2(CmdDepth + 1);

  logic [DataWidth-1:0] r_data [Depth];
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [CntW-1:0]      r_count;

  logic [CntWidth-1:0]  r_cmd_cnt [CmdDepth];
  logic [IdWidth-1:0]   r_cmd_id  [CmdDepth];
  logic [CPtrW-1:0]     r_cmd_wptr;
  logic [CPtrW-1:0]     r_cmd_rptr;
  logic [CCntW-1:0]     r_cmd_count;
  logic [CntWidth-1:0]  r_rem;

  logic             w_opnd_push;
  logic             w_cmd_push;
  logic             w_valid;
  logic             w_last;
  logic             w_pop;
  logic             w_cmd_pop;
  logic [CPtrW-1:0] w_cmd_rptr_next;

  assign opnd_ready_o    = (r_count != CntW'(Depth));
  assign cmd_ready_o     = (r_cmd_count != CCntW'(CmdDepth));
  assign w_opnd_push     = opnd_valid_i && opnd_ready_o;
  // Zero-length instructions are handshaken but never occupy a slot.
  assign w_cmd_push      = cmd_valid_i && cmd_ready_o && (cmd_cnt_i != '0);
  assign w_valid         = (r_count != '0) && (r_cmd_count != '0);
  assign w_last          = (r_rem == CntWidth'(1));
  assign w_pop           = w_valid && vfu_ready_i;
  assign w_cmd_pop       = w_pop && w_last;
  assign w_cmd_rptr_next = r_cmd_rptr + CPtrW'(1);

  assign vfu_valid_o   = w_valid;
  assign vfu_operand_o = w_valid ? r_data[r_rptr] : '0;
  assign vfu_id_o      = w_valid ? r_cmd_id[r_cmd_rptr] : '0;
  assign vfu_last_o    = w_valid && w_last;
  assign count_o       = r_count;

  always_ff @(posedge clk_i) begin
    if (w_opnd_push) r_data[r_wptr] <= opnd_i;
    if (w_cmd_push) begin
      r_cmd_cnt[r_cmd_wptr] <= cmd_cnt_i;
      r_cmd_id[r_cmd_wptr]  <= cmd_id_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_opnd_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)       r_rptr <= r_rptr + PtrW'(1);
      if (w_opnd_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_opnd_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cmd_wptr  <= '0;
      r_cmd_rptr  <= '0;
      r_cmd_count <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wptr <= r_cmd_wptr + CPtrW'(1);
      if (w_cmd_pop)  r_cmd_rptr <= w_cmd_rptr_next;
      if (w_cmd_push && !w_cmd_pop)      r_cmd_count <= r_cmd_count + CCntW'(1);
      else if (!w_cmd_push && w_cmd_pop) r_cmd_count <= r_cmd_count - CCntW'(1);
    end
  end

  // The new head is either the queued next entry or, if the FIFO drains, the command pushed this cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rem <= '0;
    end else if (w_cmd_pop) begin
      if (r_cmd_count > CCntW'(1)) r_rem <= r_cmd_cnt[w_cmd_rptr_next];
      else if (w_cmd_push)         r_rem <= cmd_cnt_i;
      else                         r_rem <= r_rem - CntWidth'(1);
    end else if (w_cmd_push && (r_cmd_count == '0)) begin
      r_rem <= cmd_cnt_i;
    end else if (w_pop) begin
      r_rem <= r_rem - CntWidth'(1);
    end
  end

  // Command counts above the counter maximum cannot be represented on cmd_cnt_i, so only underflow is checked.
  assert property (@(posedge clk_i) disable iff (rst_i) w_pop |-> (r_count != '0));

endmodule

// File: tb/tb_operand_queue.sv
// Self-checking bench for operand_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the instruction/word binding.
module tb_operand_queue;

   localparam int Depth     = 4;
   localparam int CmdDepth  = 2;
   localparam int DataWidth = 32;
   localparam int IdWidth   = 4;
   localparam int CntWidth  = 6;

   logic                       clk_i = 1'b0;
   logic                       rst_i;
   logic                       cmd_valid_i;
   logic                       cmd_ready_o;
   logic [CntWidth-1:0]        cmd_cnt_i;
   logic [IdWidth-1:0]         cmd_id_i;
   logic                       opnd_valid_i;
   logic                       opnd_ready_o;
   logic [DataWidth-1:0]       opnd_i;
   logic                       vfu_valid_o;
   logic                       vfu_ready_i;
   logic [DataWidth-1:0]       vfu_operand_o;
   logic [IdWidth-1:0]         vfu_id_o;
   logic                       vfu_last_o;
   logic [$clog2(Depth+1)-1:0] count_o;

   operand_queue #(
      .Depth(Depth), .CmdDepth(CmdDepth), .DataWidth(DataWidth),
      .IdWidth(IdWidth), .CntWidth(CntWidth)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_cnt_i(cmd_cnt_i), .cmd_id_i(cmd_id_i),
      .opnd_valid_i(opnd_valid_i), .opnd_ready_o(opnd_ready_o), .opnd_i(opnd_i),
      .vfu_valid_o(vfu_valid_o), .vfu_ready_i(vfu_ready_i),
      .vfu_operand_o(vfu_operand_o), .vfu_id_o(vfu_id_o), .vfu_last_o(vfu_last_o),
      .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   // Model: one queue of pending words, one queue of pending instructions with words still owed.
   typedef struct {
      int id;
      int rem;
   } cmd_t;

   cmd_t                 cq[$];
   logic [DataWidth-1:0] dq[$];
   int vectorCount     = 0;
   int miscompareCount = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Compares every output against what the model says the buffer should present right now.
   task automatic checkAll(input string where);
      bit ev;
      ev = (dq.size() != 0) && (cq.size() != 0);
      checkOutput({where, "/vfu_valid"}, 64'(vfu_valid_o), 64'(ev));
      checkOutput({where, "/vfu_operand"}, 64'(vfu_operand_o), ev ? 64'(dq[0]) : 64'd0);
      checkOutput({where, "/vfu_id"}, 64'(vfu_id_o), ev ? 64'(cq[0].id) : 64'd0);
      checkOutput({where, "/vfu_last"}, 64'(vfu_last_o), ev ? 64'(cq[0].rem == 1) : 64'd0);
      checkOutput({where, "/count"}, 64'(count_o), 64'(dq.size()));
      checkOutput({where, "/opnd_ready"}, 64'(opnd_ready_o), 64'(dq.size() != Depth));
      checkOutput({where, "/cmd_ready"}, 64'(cmd_ready_o), 64'(cq.size() != CmdDepth));
   endtask

   task automatic checkResetValues(input string where);
      checkOutput({where, "/vfu_valid"}, 64'(vfu_valid_o), 64'd0);
      checkOutput({where, "/vfu_operand"}, 64'(vfu_operand_o), 64'd0);
      checkOutput({where, "/vfu_id"}, 64'(vfu_id_o), 64'd0);
      checkOutput({where, "/vfu_last"}, 64'(vfu_last_o), 64'd0);
      checkOutput({where, "/count"}, 64'(count_o), 64'd0);
      checkOutput({where, "/opnd_ready"}, 64'(opnd_ready_o), 64'd1);
      checkOutput({where, "/cmd_ready"}, 64'(cmd_ready_o), 64'd1);
   endtask

   // Advances the model by one clock using the inputs currently driven.
   task automatic modelStep();
      bit   ev, pop, opush, cpush;
      cmd_t c;
      ev    = (dq.size() != 0) && (cq.size() != 0);
      pop   = ev && vfu_ready_i;
      opush = opnd_valid_i && (dq.size() != Depth);
      cpush = cmd_valid_i && (cq.size() != CmdDepth) && (cmd_cnt_i != 0);
      if (pop) begin
         void'(dq.pop_front());
         cq[0].rem = cq[0].rem - 1;
         if (cq[0].rem == 0) void'(cq.pop_front());
      end
      if (opush) dq.push_back(opnd_i);
      if (cpush) begin
         c.id  = int'(cmd_id_i);
         c.rem = int'(cmd_cnt_i);
         cq.push_back(c);
      end
   endtask

   task automatic applyStimulus(input string where, input bit cv, input int cnt, input int id,
                                input bit ov, input logic [DataWidth-1:0] od, input bit vr);
      cmd_valid_i  = cv;
      cmd_cnt_i    = CntWidth'(cnt);
      cmd_id_i     = IdWidth'(id);
      opnd_valid_i = ov;
      opnd_i       = od;
      vfu_ready_i  = vr;
      @(negedge clk_i);
      checkAll(where);
      modelStep();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [DataWidth-1:0] words [6];
      int k;
      bit acc;

      cmd_valid_i  = 1'b0;
      cmd_cnt_i    = '0;
      cmd_id_i     = '0;
      opnd_valid_i = 1'b0;
      opnd_i       = '0;
      vfu_ready_i  = 1'b0;
      rst_i        = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      checkResetValues("reset");
      rst_i = 1'b0;

      // Basic stream: one instruction of three words consumed as they arrive.
      applyStimulus("basic", 1, 3, 5, 0, 0, 1);
      applyStimulus("basic", 0, 0, 0, 1, 32'hA, 1);
      applyStimulus("basic", 0, 0, 0, 1, 32'hB, 1);
      applyStimulus("basic", 0, 0, 0, 1, 32'hC, 1);
      repeat (3) applyStimulus("basic", 0, 0, 0, 0, 0, 1);

      // Data arrives before its command.
      applyStimulus("early", 0, 0, 0, 1, 32'h11, 1);
      applyStimulus("early", 0, 0, 0, 1, 32'h22, 1);
      repeat (2) applyStimulus("early", 0, 0, 0, 0, 0, 1);
      applyStimulus("early", 1, 2, 1, 0, 0, 1);
      repeat (3) applyStimulus("early", 0, 0, 0, 0, 0, 1);

      // Backpressure: source holds each word until accepted; one-cycle VFU pop in the middle.
      applyStimulus("bp", 1, 6, 7, 0, 0, 0);
      for (int i = 0; i < 6; i++) words[i] = 32'hC0DE_0000 + i;
      k = 0;
      for (int c = 0; c < 20; c++) begin
         acc = (dq.size() != Depth);
         applyStimulus("bp", 0, 0, 0, k < 6, (k < 6) ? words[k] : '0, (c == 8) || (c >= 10));
         if (acc && k < 6) k++;
      end

      // Two commands back to back, filling the command FIFO.
      applyStimulus("two", 1, 2, 3, 0, 0, 1);
      applyStimulus("two", 1, 1, 4, 0, 0, 1);
      applyStimulus("two", 0, 0, 0, 1, 32'h301, 1);
      applyStimulus("two", 0, 0, 0, 1, 32'h302, 1);
      applyStimulus("two", 0, 0, 0, 1, 32'h401, 1);
      repeat (3) applyStimulus("two", 0, 0, 0, 0, 0, 1);

      // Zero-count command is swallowed.
      applyStimulus("zero", 1, 0, 9, 0, 0, 1);
      applyStimulus("zero", 1, 1, 10, 0, 0, 1);
      applyStimulus("zero", 0, 0, 0, 1, 32'h55, 1);
      repeat (3) applyStimulus("zero", 0, 0, 0, 0, 0, 1);

      // Reset mid-operation, asserted between clock edges.
      applyStimulus("midrst", 1, 5, 2, 1, 32'h71, 0);
      applyStimulus("midrst", 0, 0, 0, 1, 32'h72, 0);
      applyStimulus("midrst", 0, 0, 0, 1, 32'h73, 0);
      rst_i = 1'b1;
      #1;
      checkResetValues("midrst");
      dq.delete();
      cq.delete();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      applyStimulus("afterrst", 1, 1, 6, 1, 32'h99, 1);
      repeat (3) applyStimulus("afterrst", 0, 0, 0, 0, 0, 1);

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         applyStimulus("rand", ($urandom % 4) == 0, int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 15)), ($urandom % 3) != 0,
                       $urandom, ($urandom % 4) != 0);
      end
      repeat (10) applyStimulus("drain", 0, 0, 0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule

// File: doc/operand_queue.md
# operand_queue

Per-queue operand buffer sitting directly downstream of the VRF accesser's operand outputs (one instance per `op_queue_e` entry: ALUA, ALUB, StoreOp). It accepts per-instruction commands carrying the number of VRF words to expect, buffers the operand words streamed out of the VRF, and presents them to the consuming VFU. Each word is tagged with the instruction ID and a last-word flag. The accesser's one-cycle read latency is absorbed by the accesser's own one-depth buffer, so this block only has to honour a plain valid/ready handshake.

## Interface
- `Depth`, 4: operand data FIFO entries; must be a power of two, 2 or more.
- `CmdDepth`, 2: command FIFO entries; must be a power of two, 2 or more.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `cmd_valid_i` in 1: a new instruction command is offered (from `vinsn_launcher`, issued in the same cycle as the accesser request).
- `cmd_ready_o` out 1: command FIFO not full.
- `cmd_cnt_i` in `$bits(acc_cnt_t)`: number of VRF words this instruction delivers.
- `cmd_id_i` in `$bits(insn_id_t)`: instruction ID.
- `opnd_valid_i` in 1: operand word valid; driven by the accesser's `op_valid_o[i]`.
- `opnd_ready_o` out 1: data FIFO not full; drives the accesser's `op_ready_i[i]`.
- `opnd_i` in `$bits(vrf_data_t)`: operand word; driven by the accesser's `operand_o[i]`.
- `vfu_valid_o` out 1: a head operand is available and bound to a command.
- `vfu_ready_i` in 1: the VFU consumes the head operand.
- `vfu_operand_o` out `$bits(vrf_data_t)`: head operand word.
- `vfu_id_o` out `$bits(insn_id_t)`: ID of the head command.
- `vfu_last_o` out 1: the head word is the final word of its instruction.
- `count_o` out `$clog2(Depth+1)`: data FIFO occupancy.

## Operation
- **Command FIFO**
  - Push on `cmd_valid_i && cmd_ready_o`.
  - A command with `cmd_cnt_i == 0` is accepted and discarded; it is not enqueued.
- **Data FIFO**
  - Push on `opnd_valid_i && opnd_ready_o`.
  - Data is accepted regardless of command FIFO state. Words may arrive before their command becomes head, but ordering is preserved.
- **Remaining-word counter** (`rem_q`, width `acc_cnt_t`)
  - Loaded with the head command's count whenever a command becomes head: on a push into an empty command FIFO, or on a pop that leaves another entry behind.
- **Output**
  - `vfu_valid_o` = data FIFO non-empty AND command FIFO non-empty.
  - `vfu_id_o` = head command ID.
  - `vfu_last_o` = (`rem_q == 1`).
  - When `vfu_valid_o` is 0, `vfu_operand_o`, `vfu_id_o` and `vfu_last_o` are forced to 0.
- **Pop** on `vfu_valid_o && vfu_ready_i`:
  - Always: pop the data FIFO and decrement `rem_q`.
  - If `vfu_last_o` is also 1: pop the command FIFO and reload `rem_q` from the next head. If no next head exists, `rem_q` becomes don't-care.
- **Status**
  - `count_o` tracks data FIFO occupancy exactly.
  - `opnd_ready_o` = `count_o != Depth`. It does not depend combinationally on `vfu_ready_i`, so a pop does not free a slot in the same cycle.
  - `cmd_ready_o` follows the same rule for the command FIFO.
- **Pointers**: read and write pointers are `$clog2(Depth)` bits and wrap modulo `Depth`. Full/empty is derived from a separate occupancy counter, not from pointer equality.
- **Assertions** (simulation only):
  - Pop never happens while the data FIFO is empty.
  - Pushed `cmd_cnt_i` is at most the acc_cnt_t maximum.

## Timing
- **Reset (`rst_i` high, async)**:
  - `vfu_valid_o` = 0, `count_o` = 0, `cmd_ready_o` = 1, `opnd_ready_o` = 1.
  - `vfu_operand_o`, `vfu_id_o`, `vfu_last_o` = 0.
  - FIFO storage is not reset.
  - Reset mid-instruction drops all buffered words and commands; the first cycle after deassertion behaves as a fresh start.
- **Latency**: no fall-through. A word pushed in cycle t (with its command already head) shows on `vfu_valid_o` at t+1. A command pushed in cycle t binds at the earliest at t+1.
- **Full data FIFO**: `opnd_ready_o` = 0. A simultaneous VFU pop lowers occupancy; `opnd_ready_o` returns to 1 in the next cycle.
- **Empty data FIFO**: a push and no pop in the same cycle is the only legal update; there is no bypass to the output.
- **Push and pop in the same cycle** on a non-full, non-empty FIFO: `count_o` is unchanged and both pointers advance.
- **Back-to-back instructions**: the last word of instruction A and the first word of B pop in consecutive cycles with no bubble. `vfu_id_o` changes in the cycle after A's last pop.
- **Throughput**: one word per cycle in steady state, whenever `Depth` ≥ 2.

## Test plan
- **Basic stream**: reset, push cmd (cnt=3, id=5), stream words 0xA,0xB,0xC with `vfu_ready_i` = 1 → `vfu_valid_o` on the three cycles following each push; `vfu_id_o` = 5; `vfu_last_o` only on 0xC; `count_o` returns to 0.
- **Data before command**: push two words, then cmd (cnt=2, id=1) two cycles later → `vfu_valid_o` stays 0 until the cycle after the cmd push, then both words emerge in order; last on the second.
- **Backpressure**: `Depth` = 4, `vfu_ready_i` = 0, offer 6 words → 4 accepted, `opnd_ready_o` = 0, `count_o` = 4. Raise `vfu_ready_i` for 1 cycle → `opnd_ready_o` = 1 next cycle. Pointers wrap and all 6 words come out in order.
- **Two commands**: cmds (cnt=2, id=3), (cnt=1, id=4) queued; `cmd_ready_o` = 0 after the second push (`CmdDepth` = 2). Stream 3 words → ids 3,3,4 with last = 0,1,1 and no bubble.
- **Zero count**: push cmd cnt=0 then cmd cnt=1 → the zero-count command never appears; the single word carries the second ID with last = 1.
- **Reset mid-operation**: assert `rst_i` with 3 words and 1 cmd buffered → all outputs return to their reset values immediately (async). After release, a fresh cmd/word pair passes normally.
